processador_multiciclo: RTL and testbench
=========================================

PROCESSADOR_MULTICICLO -- requirements
Module: processador_multiciclo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register/ALU/data-bus width (>=4).
REQ-002 SHALL have parameter ADDR_W, default 8, PC, jump-register and memory address width (>=4).
REQ-003 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: imem_req out 1, imem_addr out ADDR_W, imem_ack in 1, imem_rdata in 8; instruction fetch handshake.
REQ-007 SHALL have ports: dmem_req out 1, dmem_we out 1, dmem_addr out ADDR_W, dmem_wdata out DATA_W, dmem_ack in 1, dmem_rdata in DATA_W; data handshake.
REQ-008 SHALL have ports: halted out 1, pc_out out ADDR_W, instr_count out CNT_W; status/debug.

Function
REQ-009 SHALL decode instruction byte as opcode=[7:4], ra=[3:2], rb=[1:0], imm4=[3:0], imm2=[1:0]; four DATA_W registers r0..r3.
REQ-010 SHALL implement opcodes: 0 NOP; 1 ADD ra<=ra+rb; 2 SUB ra<=ra-rb; 3 AND; 4 OR; 5 SLT ra<=(ra<rb unsigned)?1:0; 6 SHL ra<=ra<<imm2; 7 SHR ra<=ra>>imm2 (logical).
REQ-011 SHALL implement: 8 LI r0<=zero-ext imm4; 9 LW ra<=mem[rb]; A SW mem[rb]<=ra; B SJ JR<=rb; C BEQ if ra==rb PC<=JR; D BNE if ra!=rb PC<=JR; E JMP PC<=JR; F HLT.
REQ-012 SHALL wrap all arithmetic modulo 2^DATA_W; addresses from registers use low ADDR_W bits, zero-extended when DATA_W<ADDR_W.
REQ-013 SHALL use FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 FETCH: imem_req=1, imem_addr=PC; on imem_ack latch IR, PC<=PC+1 (mod 2^ADDR_W), go DECODE; else stay.
REQ-015 DECODE: read ra/rb into operand latches, go EXEC (exactly 1 cycle).
REQ-016 EXEC: ALU/LI/SJ/NOP/branch/JMP complete here (register, JR or PC write), go FETCH; LW/SW go MEM; HLT goes HALT.
REQ-017 MEM: dmem_req=1, dmem_addr=rb, dmem_we=1 only for SW, dmem_wdata=ra; on dmem_ack SW goes FETCH, LW latches dmem_rdata and goes WB.
REQ-018 WB: write LW data to ra, go FETCH (1 cycle).
REQ-019 HALT: halted=1, no requests, state held until reset.
REQ-020 SHALL hold req high with address/data/we stable until ack sampled high; req SHALL drop in the cycle following ack.
REQ-021 SHALL ignore imem_ack/dmem_ack when corresponding req is low.
REQ-022 Taken branch/JMP target overrides the incremented PC; not-taken leaves PC+1.
REQ-023 instr_count SHALL increment by 1 when each instruction completes (FETCH re-entry or HALT entry), wrapping at 2^CNT_W.
REQ-024 Zero-wait latencies: ALU/branch 3 cycles, SW 4, LW 5.
REQ-025 pc_out SHALL equal PC register at all times.

Reset
REQ-026 While reset=1 at a clock edge: PC=0, JR=0, r0..r3=0, IR=0, instr_count=0, state=FETCH, halted=0.
REQ-027 imem_req and dmem_req SHALL be 0 during any cycle reset=1, including reset mid-handshake; acks during reset are discarded.
REQ-028 First fetch (addr 0) SHALL request in the first cycle after reset deasserts; reset SHALL exit HALT.

Verification
REQ-029 Program LI 5; LI? no: 0x85,0x11(ADD r0,r1? r0+=r1=0) with zero-wait acks -> r0=5 after 6 cycles, instr_count=2, pc_out=2.
REQ-030 imem_ack delayed 3 cycles -> imem_req and imem_addr held stable 4 cycles, single IR latch, PC advances exactly once.
REQ-031 r1=3, r2=0x2A, SW r2,[r1] then LW r3,[r1] -> dmem write addr 3 data 0x2A, dmem_we=1 only on SW; r3=0x2A.
REQ-032 SJ to 0x10, BEQ r0,r0 -> pc_out=0x10; BNE r0,r0 -> pc_out=prior PC+1; PC at 2^ADDR_W-1 fetch wraps to 0.
REQ-033 HLT -> halted=1, no req for 20 cycles, instr_count frozen; reset asserted mid dmem handshake -> dmem_req=0 same cycle, all state cleared.
REQ-034 DATA_W=16: 0xFFFF+1 via ADD -> 0, SUB 0-1 -> 0xFFFF, SLT 0xFFFF<1 -> 0.

Source files
------------

// File: rtl/processador_multiciclo.sv
// Multi-cycle 8-bit-instruction processor: FETCH/DECODE/EXEC/MEM/WB/HALT
// control with req/ack handshakes to separate instruction and data memories.
module processador_multiciclo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_OR  = 4'h4, OP_SLT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
        OP_LI  = 4'h8, OP_LW  = 4'h9, OP_SW  = 4'hA, OP_SJ  = 4'hB,
        OP_BEQ = 4'hC, OP_BNE = 4'hD, OP_JMP = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, jr;
    logic [7:0]        ir;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] a_q, b_q, mdr, alu_result;
    logic [CNT_W-1:0]  count_q;
    logic              instr_done;

    opcode_t    opcode;
    logic [1:0] ra, rb;

    assign opcode = opcode_t'(ir[7:4]);
    assign ra     = ir[3:2];
    assign rb     = ir[1:0];

    // Register/operand addresses take the low ADDR_W bits, zero-extended if narrower.
    assign imem_addr   = pc;
    assign dmem_addr   = ADDR_W'(b_q);
    assign dmem_wdata  = a_q;
    assign pc_out      = pc;
    assign instr_count = count_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop update from pre-edge values.
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next-state and handshake outputs; reset gates both requests in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                if (opcode == OP_LW || opcode == OP_SW) state_next = MEM;
                else if (opcode == OP_HLT)              state_next = HALT;
                else                                    state_next = FETCH;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_SW);
                if (dmem_ack) state_next = (opcode == OP_SW) ? FETCH : WB;
            end
            WB:      state_next = FETCH;
            HALT:    halted = 1'b1;
            default: state_next = FETCH;
        endcase
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
        end
    end

    // An instruction retires whenever control returns to FETCH or parks in HALT.
    assign instr_done = (state_next == FETCH || state_next == HALT)
                        && state != FETCH && state != HALT;

    // ALU for the register-register and shift-by-immediate opcodes.
    always_comb begin
        alu_result = a_q;
        case (opcode)
            OP_ADD: alu_result = a_q + b_q;
            OP_SUB: alu_result = a_q - b_q;
            OP_AND: alu_result = a_q & b_q;
            OP_OR:  alu_result = a_q | b_q;
            OP_SLT: alu_result = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
            OP_SHL: alu_result = a_q << rb;
            OP_SHR: alu_result = a_q >> rb;
            default: alu_result = a_q;
        endcase
    end

    // Datapath: IR/PC on fetch, operand latches, execute writes, load data, retire count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            jr      <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mdr     <= '0;
            count_q <= '0;
            // NOTE: the four-entry register file must read as zero after reset, so it is reset like plain flops.
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (state == FETCH && imem_ack) begin
                ir <= imem_rdata;
                pc <= pc + ADDR_W'(1);
            end
            if (state == DECODE) begin
                a_q <= regs[ra];
                b_q <= regs[rb];
            end
            if (state == EXEC) begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_SLT, OP_SHL, OP_SHR: regs[ra] <= alu_result;
                    OP_LI:  regs[0] <= DATA_W'(ir[3:0]);
                    OP_SJ:  jr <= ADDR_W'(b_q);
                    OP_BEQ: if (a_q == b_q) pc <= jr;
                    OP_BNE: if (a_q != b_q) pc <= jr;
                    OP_JMP: pc <= jr;
                    default: ;
                endcase
            end
            if (state == MEM && dmem_ack && opcode == OP_LW) mdr <= dmem_rdata;
            if (state == WB) regs[ra] <= mdr;
            if (instr_done) count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_processador_multiciclo.sv
// Self-checking bench: directed handshake/branch/reset sequences, an ALU vector
// table, and random programs against an instruction-level reference model.
module tb_processador_multiciclo;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk, reset;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_rdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          halted;
    logic [AW-1:0] pc_out;
    logic [CW-1:0] instr_count;

    processador_multiciclo #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halted(halted), .pc_out(pc_out), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        logic [3:0]    op;
        logic [1:0]    imm2;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } alu_vec_t;

    logic [7:0]    imem [256];
    logic [DW-1:0] dmem [256];
    txn_t          obs_q[$];
    txn_t          exp_q[$];
    logic [AW-1:0] exp_pc;
    int            exp_count;
    int            n_checks, n_errors;
    int            i_lat_cfg, d_lat_cfg, stab_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(2, 0)) : cfg;
    endfunction

    // Memory responder: acks after a chosen latency, records data transactions,
    // and flags any request whose address/data/we moves before the ack.
    initial begin : responder
        int            i_cnt, i_lat, d_cnt, d_lat;
        bit            i_busy, d_busy;
        logic [AW-1:0] i_addr0, d_addr0;
        logic [DW-1:0] d_wd0;
        logic          d_we0;
        txn_t          t;
        i_cnt = 0; i_lat = 0; d_cnt = 0; d_lat = 0; i_busy = 0; d_busy = 0;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (imem_req === 1'b1) begin
                if (!i_busy) begin
                    i_busy = 1; i_addr0 = imem_addr;
                end else if (imem_addr !== i_addr0) stab_err++;
                if (i_cnt >= i_lat) begin
                    imem_ack = 1'b1; imem_rdata = imem[imem_addr];
                end else begin
                    imem_ack = 1'b0; imem_rdata = 8'($urandom); i_cnt++;
                end
            end else begin
                i_busy = 0; i_cnt = 0; imem_ack = 1'b0;
                imem_rdata = 8'($urandom); i_lat = pick(i_lat_cfg);
            end
            if (dmem_req === 1'b1) begin
                if (!d_busy) begin
                    d_busy = 1; d_addr0 = dmem_addr; d_we0 = dmem_we; d_wd0 = dmem_wdata;
                end else if (dmem_addr !== d_addr0 || dmem_we !== d_we0 || dmem_wdata !== d_wd0)
                    stab_err++;
                if (d_cnt >= d_lat) begin
                    dmem_ack = 1'b1;
                    t.we = dmem_we; t.addr = dmem_addr; t.data = dmem_wdata;
                    obs_q.push_back(t);
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = dmem[dmem_addr];
                end else begin
                    dmem_ack = 1'b0; dmem_rdata = DW'($urandom); d_cnt++;
                end
            end else begin
                d_busy = 0; d_cnt = 0; dmem_ack = 1'b0;
                dmem_rdata = DW'($urandom); d_lat = pick(d_lat_cfg);
            end
        end
    end

    // Instruction-level reference: executes imem from address 0 until HLT.
    task automatic model_run(input int max_steps, output bit ok);
        logic [AW-1:0] pc, jr, ad;
        logic [7:0]    ir;
        logic [DW-1:0] r [4];
        logic [DW-1:0] mem [256];
        logic [1:0]    ra, rb;
        txn_t          t;
        int            cnt;
        pc = '0; jr = '0; cnt = 0; ok = 0;
        for (int i = 0; i < 4; i++) r[i] = '0;
        for (int i = 0; i < 256; i++) mem[i] = dmem[i];
        exp_q.delete();
        for (int s = 0; s < max_steps; s++) begin
            ir = imem[pc]; pc = pc + 8'd1; cnt++;
            ra = ir[3:2]; rb = ir[1:0];
            case (ir[7:4])
                4'h1: r[ra] = r[ra] + r[rb];
                4'h2: r[ra] = r[ra] - r[rb];
                4'h3: r[ra] = r[ra] & r[rb];
                4'h4: r[ra] = r[ra] | r[rb];
                4'h5: r[ra] = (r[ra] < r[rb]) ? DW'(1) : DW'(0);
                4'h6: r[ra] = r[ra] << rb;
                4'h7: r[ra] = r[ra] >> rb;
                4'h8: r[0] = DW'(ir[3:0]);
                4'h9: begin
                    ad = r[rb][AW-1:0];
                    t.we = 1'b0; t.addr = ad; t.data = '0; exp_q.push_back(t);
                    r[ra] = mem[ad];
                end
                4'hA: begin
                    ad = r[rb][AW-1:0];
                    t.we = 1'b1; t.addr = ad; t.data = r[ra]; exp_q.push_back(t);
                    mem[ad] = r[ra];
                end
                4'hB: jr = r[rb][AW-1:0];
                4'hC: if (r[ra] == r[rb]) pc = jr;
                4'hD: if (r[ra] != r[rb]) pc = jr;
                4'hE: pc = jr;
                4'hF: ok = 1;
                default: ;
            endcase
            if (ok) begin
                exp_pc = pc; exp_count = cnt;
                break;
            end
        end
    endtask

    task automatic fill_imem_halt();
        for (int i = 0; i < 256; i++) imem[i] = 8'hF0;
    endtask

    // Leaves reset asserted at a falling edge after two rising edges.
    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        obs_q.delete();
        stab_err = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        #2;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk); #2; n++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        #2;
        while (instr_count !== CW'(target) && n < budget) begin
            @(negedge clk); #2; n++;
        end
        check($sformatf("count_reached_%0d", target), instr_count, target);
    endtask

    task automatic run_prog(input int budget);
        hold_reset();
        reset = 1'b0;
        wait_halt(budget);
    endtask

    task automatic compare_all(input string pfx);
        int n;
        check({pfx, "_ntxn"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_txn%0d_we", pfx, i), obs_q[i].we, exp_q[i].we);
            check($sformatf("%s_txn%0d_addr", pfx, i), obs_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check($sformatf("%s_txn%0d_data", pfx, i), obs_q[i].data, exp_q[i].data);
        end
        check({pfx, "_pc"}, pc_out, exp_pc);
        check({pfx, "_count"}, instr_count, exp_count);
        check({pfx, "_stable"}, stab_err, 0);
    endtask

    initial begin : main
        alu_vec_t vecs [13];
        bit       ok;
        int       req_seen;

        n_checks = 0; n_errors = 0; stab_err = 0;
        i_lat_cfg = 0; d_lat_cfg = 0;
        reset = 1'b1;
        fill_imem_halt();
        for (int i = 0; i < 256; i++) dmem[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #2;
        check("rst_pc", pc_out, 0);
        check("rst_count", instr_count, 0);
        check("rst_halted", halted, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);

        // LI 5; ADD r0,r1; SW r0,[r1]; HLT with zero-wait memories.
        imem[0] = 8'h85; imem[1] = 8'h11; imem[2] = 8'hA1; imem[3] = 8'hF0;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("first_fetch_req", imem_req, 1);
        check("first_fetch_addr", imem_addr, 0);
        repeat (6) @(posedge clk);
        @(negedge clk); #2;
        check("two_instr_count", instr_count, 2);
        check("two_instr_pc", pc_out, 2);
        wait_halt(200);
        check("r0_store_n", obs_q.size(), 1);
        if (obs_q.size() >= 1) begin
            check("r0_store_addr", obs_q[0].addr, 0);
            check("r0_store_data", obs_q[0].data, 5);
        end

        // Instruction ack delayed three cycles: request held four cycles, PC moves once.
        fill_imem_halt();
        imem[0] = 8'h85;
        i_lat_cfg = 3;
        hold_reset();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("slow_req_c%0d", k), imem_req, 1);
            check($sformatf("slow_addr_c%0d", k), imem_addr, 0);
            check($sformatf("slow_pc_c%0d", k), pc_out, 0);
            @(negedge clk);
        end
        #2;
        check("slow_req_drop", imem_req, 0);
        check("slow_pc_once", pc_out, 1);
        wait_halt(200);
        check("slow_count", instr_count, 2);
        check("slow_pc_end", pc_out, 2);
        check("slow_stable", stab_err, 0);
        i_lat_cfg = -1;

        // r1=3, r2=0x2A; SW r2,[r1]; LW r3,[r1]; SW r3,[r0=2].
        fill_imem_halt();
        imem[0] = 8'h83; imem[1] = 8'h14; imem[2] = 8'h85; imem[3] = 8'h18;
        imem[4] = 8'h6B; imem[5] = 8'h82; imem[6] = 8'h18; imem[7] = 8'hA9;
        imem[8] = 8'h9D; imem[9] = 8'hAC;
        d_lat_cfg = -1;
        run_prog(1000);
        check("ldst_ntxn", obs_q.size(), 3);
        if (obs_q.size() >= 3) begin
            check("sw_we", obs_q[0].we, 1);
            check("sw_addr", obs_q[0].addr, 3);
            check("sw_data", obs_q[0].data, 16'h002A);
            check("lw_we", obs_q[1].we, 0);
            check("lw_addr", obs_q[1].addr, 3);
            check("lw_r3_data", obs_q[2].data, 16'h002A);
        end
        check("ldst_count", instr_count, 11);

        // SJ 0x10 + BEQ taken, BNE not taken, then JMP to 0xFF whose fetch wraps PC to 0.
        fill_imem_halt();
        imem[0] = 8'h84; imem[1] = 8'h62; imem[2] = 8'hB0; imem[3] = 8'hC0;
        imem[8'h10] = 8'hD0; imem[8'h11] = 8'h25; imem[8'h12] = 8'h81;
        imem[8'h13] = 8'h24; imem[8'h14] = 8'hB1; imem[8'h15] = 8'hE0;
        hold_reset();
        reset = 1'b0;
        wait_count(4, 200);
        check("beq_taken_pc", pc_out, 8'h10);
        wait_count(5, 200);
        check("bne_not_taken_pc", pc_out, 8'h11);
        wait_halt(300);
        check("wrap_pc", pc_out, 0);
        check("wrap_count", instr_count, 11);

        // Halted: no requests, counter frozen, reset leaves HALT.
        req_seen = 0;
        repeat (20) begin
            @(negedge clk); #2;
            if (imem_req !== 1'b0 || dmem_req !== 1'b0) req_seen++;
        end
        check("halt_no_req", req_seen, 0);
        check("halt_held", halted, 1);
        check("halt_count_frozen", instr_count, 11);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #2;
        check("halt_exit_halted", halted, 0);
        check("halt_exit_pc", pc_out, 0);

        // Reset in the middle of a stalled store.
        fill_imem_halt();
        imem[0] = 8'h83; imem[1] = 8'hA0;
        model_run(50, ok);
        d_lat_cfg = 1000;
        hold_reset();
        reset = 1'b0;
        begin
            int n = 0;
            #2;
            while (dmem_req !== 1'b1 && n < 50) begin
                @(negedge clk); #2; n++;
            end
        end
        check("mid_dmem_req_seen", dmem_req, 1);
        reset = 1'b1;
        #1;
        check("mid_dmem_req_drop", dmem_req, 0);
        check("mid_imem_req_off", imem_req, 0);
        @(negedge clk); #2;
        check("mid_pc_clear", pc_out, 0);
        check("mid_count_clear", instr_count, 0);
        check("mid_no_txn", obs_q.size(), 0);
        d_lat_cfg = 0;
        run_prog(200);
        compare_all("mid_rerun");
        d_lat_cfg = -1;

        // ALU table: r1=mem[1], r2=mem[2], op r1,(r2|imm2), SW r1,[3].
        vecs[0]  = '{4'h1, 2'd0, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[1]  = '{4'h2, 2'd0, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[2]  = '{4'h5, 2'd0, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[3]  = '{4'h5, 2'd0, 16'h0001, 16'hFFFF, 16'h0001};
        vecs[4]  = '{4'h3, 2'd0, 16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[5]  = '{4'h4, 2'd0, 16'hF0F0, 16'h0F01, 16'hFFF1};
        vecs[6]  = '{4'h6, 2'd1, 16'h8001, 16'h1234, 16'h0002};
        vecs[7]  = '{4'h7, 2'd3, 16'h8001, 16'h1234, 16'h1000};
        vecs[8]  = '{4'h1, 2'd0, 16'h1234, 16'h4321, 16'h5555};
        vecs[9]  = '{4'h2, 2'd0, 16'h0005, 16'h0005, 16'h0000};
        vecs[10] = '{4'h6, 2'd0, 16'h00FF, 16'h0003, 16'h00FF};
        vecs[11] = '{4'h0, 2'd0, 16'hABCD, 16'h1111, 16'hABCD};
        vecs[12] = '{4'h5, 2'd0, 16'h0005, 16'h0005, 16'h0000};
        for (int v = 0; v < 13; v++) begin
            fill_imem_halt();
            imem[0] = 8'h81; imem[1] = 8'h94; imem[2] = 8'h82; imem[3] = 8'h98;
            imem[4] = {vecs[v].op, 2'b01,
                       (vecs[v].op == 4'h6 || vecs[v].op == 4'h7) ? vecs[v].imm2 : 2'b10};
            imem[5] = 8'h83; imem[6] = 8'hA4;
            dmem[1] = vecs[v].a; dmem[2] = vecs[v].b;
            run_prog(500);
            check($sformatf("alu%0d_ntxn", v), obs_q.size(), 3);
            if (obs_q.size() >= 3) begin
                check($sformatf("alu%0d_addr", v), obs_q[2].addr, 3);
                check($sformatf("alu%0d_data", v), obs_q[2].data, vecs[v].exp);
            end
            check($sformatf("alu%0d_count", v), instr_count, 8);
        end

        // Random programs against the reference model.
        for (int p = 0; p < 10; p++) begin
            for (int attempt = 0; attempt < 50; attempt++) begin
                fill_imem_halt();
                for (int i = 0; i < 32; i++) imem[i] = 8'($urandom);
                for (int i = 0; i < 256; i++) dmem[i] = DW'($urandom);
                model_run(400, ok);
                if (ok) break;
            end
            run_prog(8000);
            compare_all($sformatf("rand%0d", p));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
